// File: rtl/reorder_buffer.sv
// In-order retirement reorder buffer: circular entry array with head/tail pointers,
// writeback by tag, one registered commit per cycle. Define ROB_FLUSH_EN to add a flush port.

module reorder_buffer_entry (
    input  logic        clk,
    input  logic        reset,
`ifdef ROB_FLUSH_EN
    input  logic        clear,
`endif
    input  logic        alloc,
    input  logic [4:0]  alloc_dest,
    input  logic        wb,
    input  logic [15:0] wb_data,
    input  logic        retire,
    output logic        valid,
    output logic        done,
    output logic [4:0]  dest,
    output logic [15:0] data
);

    // Retire and allocate never target the same slot in one cycle: a full buffer refuses allocation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            done  <= 1'b0;
            dest  <= '0;
            data  <= '0;
        end
`ifdef ROB_FLUSH_EN
        else if (clear) begin
            valid <= 1'b0;
            done  <= 1'b0;
        end
`endif
        else begin
            if (retire) begin
                valid <= 1'b0;
                done  <= 1'b0;
            end else if (alloc) begin
                valid <= 1'b1;
                done  <= 1'b0;
                dest  <= alloc_dest;
            end else if (wb) begin
                done  <= 1'b1;
                data  <= wb_data;
            end
        end
    end

endmodule

module reorder_buffer #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             reset,
`ifdef ROB_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_dest,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [15:0]      wb_data,
    output logic             commit_en,
    output logic [4:0]       commit_reg,
    output logic [15:0]      commit_data,
    output logic [TAG_W:0]   count
);

    logic [TAG_W-1:0]        head, tail;
    logic [TAG_W:0]          cnt;
    logic [DEPTH-1:0]        valid_vec, done_vec;
    logic [DEPTH-1:0][4:0]   dest_arr;
    logic [DEPTH-1:0][15:0]  data_arr;
    logic                    alloc_fire, wb_hit, retire;

    assign alloc_ready = cnt < (TAG_W+1)'(DEPTH);
    assign alloc_tag   = tail;
    assign count       = cnt;

    assign alloc_fire  = alloc_valid & alloc_ready;
    // Writebacks to a slot that is not yet allocated are dropped.
    assign wb_hit      = wb_valid & valid_vec[wb_tag];
    assign retire      = valid_vec[head] & done_vec[head];

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        reorder_buffer_entry u_ent (
            .clk        (clk),
            .reset      (reset),
`ifdef ROB_FLUSH_EN
            .clear      (flush),
`endif
            .alloc      (alloc_fire && tail == TAG_W'(i)),
            .alloc_dest (alloc_dest),
            .wb         (wb_hit && wb_tag == TAG_W'(i)),
            .wb_data    (wb_data),
            .retire     (retire && head == TAG_W'(i)),
            .valid      (valid_vec[i]),
            .done       (done_vec[i]),
            .dest       (dest_arr[i]),
            .data       (data_arr[i])
        );
    end

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end
`ifdef ROB_FLUSH_EN
        else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end
`endif
        else begin
            if (alloc_fire)
                tail <= tail + TAG_W'(1);
            if (retire)
                head <= head + TAG_W'(1);
            case ({alloc_fire, retire})
                2'b10:   cnt <= cnt + (TAG_W+1)'(1);
                2'b01:   cnt <= cnt - (TAG_W+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_en   <= 1'b0;
            commit_reg  <= '0;
            commit_data <= '0;
        end
`ifdef ROB_FLUSH_EN
        else if (flush) begin
            commit_en   <= 1'b0;
        end
`endif
        else begin
            commit_en <= retire;
            if (retire) begin
                commit_reg  <= dest_arr[head];
                commit_data <= data_arr[head];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: commit, ordering, full, wrap, async reset, optional flush.

module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        reset;
`ifdef ROB_FLUSH_EN
    logic        flush = 1'b0;
`endif
    logic        alloc_valid;
    logic [4:0]  alloc_dest;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        wb_valid;
    logic [2:0]  wb_tag;
    logic [15:0] wb_data;
    logic        commit_en;
    logic [4:0]  commit_reg;
    logic [15:0] commit_data;
    logic [3:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    reorder_buffer #(.DEPTH(8), .TAG_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef ROB_FLUSH_EN
        .flush       (flush),
`endif
        .alloc_valid (alloc_valid),
        .alloc_dest  (alloc_dest),
        .alloc_ready (alloc_ready),
        .alloc_tag   (alloc_tag),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .wb_data     (wb_data),
        .commit_en   (commit_en),
        .commit_reg  (commit_reg),
        .commit_data (commit_data),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        alloc_valid = 1'b0; alloc_dest = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_data = '0;
        #2;
        chk("rst_count",  32'(count), 32'd0);
        chk("rst_cen",    32'(commit_en), 32'd0);
        chk("rst_creg",   32'(commit_reg), 32'd0);
        chk("rst_cdata",  32'(commit_data), 32'd0);
        chk("rst_ready",  32'(alloc_ready), 32'd1);
        chk("rst_tag",    32'(alloc_tag), 32'd0);
        reset = 1'b0;

        // basic commit
        alloc_valid = 1'b1; alloc_dest = 5'd5;
        tick;
        chk("b_count1", 32'(count), 32'd1);
        chk("b_tag1",   32'(alloc_tag), 32'd1);
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 16'h1234;
        tick;
        chk("b_cen_k",  32'(commit_en), 32'd0);
        wb_valid = 1'b0;
        tick;
        chk("b_cen",    32'(commit_en), 32'd1);
        chk("b_creg",   32'(commit_reg), 32'd5);
        chk("b_cdata",  32'(commit_data), 32'h1234);
        chk("b_count0", 32'(count), 32'd0);
        tick;
        chk("b_cen_off", 32'(commit_en), 32'd0);
        chk("b_hold",    32'(commit_reg), 32'd5);

        // in-order retire with reversed writebacks
        pulse_reset;
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1; alloc_dest = 5'(10 + i);
            tick;
        end
        alloc_valid = 1'b0;
        chk("o_count3", 32'(count), 32'd3);
        for (int i = 2; i >= 0; i--) begin
            wb_valid = 1'b1; wb_tag = 3'(i); wb_data = 16'(16'hAAA0 + i);
            tick;
            chk("o_cen_wait", 32'(commit_en), 32'd0);
        end
        wb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("o_cen",   32'(commit_en), 32'd1);
            chk("o_creg",  32'(commit_reg), 32'(10 + i));
            chk("o_cdata", 32'(commit_data), 32'(16'hAAA0 + i));
        end
        tick;
        chk("o_cen_end", 32'(commit_en), 32'd0);
        chk("o_count0",  32'(count), 32'd0);

        // full boundary
        pulse_reset;
        for (int i = 0; i < 8; i++) begin
            alloc_valid = 1'b1; alloc_dest = 5'(16 + i);
            tick;
        end
        chk("f_ready", 32'(alloc_ready), 32'd0);
        chk("f_count", 32'(count), 32'd8);
        chk("f_tag",   32'(alloc_tag), 32'd0);
        alloc_dest = 5'd31;
        tick;
        chk("f_count9", 32'(count), 32'd8);
        chk("f_tag9",   32'(alloc_tag), 32'd0);
        wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 16'hBEEF;
        tick;
        chk("f_count_wb", 32'(count), 32'd8);
        wb_valid = 1'b0;
        tick;
        chk("f_ret_cen",   32'(commit_en), 32'd1);
        chk("f_ret_creg",  32'(commit_reg), 32'd16);
        chk("f_ret_cdata", 32'(commit_data), 32'hBEEF);
        chk("f_ret_count", 32'(count), 32'd7);
        chk("f_ret_tag",   32'(alloc_tag), 32'd0);
        tick;
        chk("f_re_count", 32'(count), 32'd8);
        chk("f_re_tag",   32'(alloc_tag), 32'd1);
        alloc_valid = 1'b0;

        // wrap-around with overlapping alloc/writeback/commit
        pulse_reset;
        for (int c = 0; c < 23; c++) begin
            alloc_valid = (c < 20);
            alloc_dest  = 5'((c + 3) % 32);
            wb_valid    = (c >= 1 && c <= 20);
            wb_tag      = 3'((c + 7) % 8);
            wb_data     = 16'(16'h5000 + c - 1);
            if (c < 20)
                chk("w_tag", 32'(alloc_tag), 32'(c % 8));
            tick;
            if (c >= 2 && c <= 21) begin
                chk("w_cen",   32'(commit_en), 32'd1);
                chk("w_creg",  32'(commit_reg), 32'((c + 1) % 32));
                chk("w_cdata", 32'(commit_data), 32'(16'h5000 + c - 2));
            end else begin
                chk("w_cen_idle", 32'(commit_en), 32'd0);
            end
        end
        alloc_valid = 1'b0; wb_valid = 1'b0;
        chk("w_count0", 32'(count), 32'd0);

        // asynchronous reset mid-cycle with entries pending and a commit in flight
        pulse_reset;
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1; alloc_dest = 5'(20 + i);
            tick;
        end
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 16'h1111;
        tick;
        wb_tag = 3'd1; wb_data = 16'h2222;
        tick;
        wb_valid = 1'b0;
        chk("r_pre_cen", 32'(commit_en), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("r_count", 32'(count), 32'd0);
        chk("r_cen",   32'(commit_en), 32'd0);
        chk("r_tag",   32'(alloc_tag), 32'd0);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("r_no_commit", 32'(commit_en), 32'd0);
        end

`ifdef ROB_FLUSH_EN
        // flush beats a concurrent alloc and a pending retire
        pulse_reset;
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1; alloc_dest = 5'(i + 1);
            tick;
        end
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 16'h7777;
        tick;
        wb_valid = 1'b0;
        flush = 1'b1; alloc_valid = 1'b1;
        tick;
        flush = 1'b0; alloc_valid = 1'b0;
        chk("x_count", 32'(count), 32'd0);
        chk("x_tag",   32'(alloc_tag), 32'd0);
        chk("x_cen",   32'(commit_en), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("x_no_commit", 32'(commit_en), 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of entries; power of two, at least 2.
REQ-002 SHALL have parameter TAG_W, default 3: tag width, equal to log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port alloc_valid, input, 1 bit: dispatch requests a new entry.
REQ-006 SHALL have port alloc_dest, input, 5 bits: destination architectural register of the new entry.
REQ-007 SHALL have port alloc_ready, output, 1 bit: an entry is free.
REQ-008 SHALL have port alloc_tag, output, TAG_W bits: tag the next allocation receives.
REQ-009 SHALL have port wb_valid, input, 1 bit: result broadcast present.
REQ-010 SHALL have port wb_tag, input, TAG_W bits: entry that the result belongs to.
REQ-011 SHALL have port wb_data, input, 16 bits: result value.
REQ-012 SHALL have port commit_en, output, 1 bit: register-file write strobe.
REQ-013 SHALL have port commit_reg, output, 5 bits: register-file write address.
REQ-014 SHALL have port commit_data, output, 16 bits: register-file write data.
REQ-015 SHALL have port count, output, TAG_W+1 bits: number of occupied entries.

Function
REQ-016 SHALL be a circular buffer with head and tail pointers; each entry holds a valid bit, a done bit, a 5-bit dest field and a 16-bit data field.
REQ-017 SHALL drive alloc_ready = (count < DEPTH) and alloc_tag = tail, both combinational from registered state.
REQ-018 SHALL allocate when alloc_valid and alloc_ready are both 1 at a rising edge: entry[tail] gets valid=1, done=0, dest=alloc_dest; tail increments modulo DEPTH.
REQ-019 SHALL ignore alloc_valid while alloc_ready is 0; the buffer state does not change.
REQ-020 SHALL, on wb_valid=1 with entry[wb_tag].valid=1, set done=1 and data=wb_data; a writeback to an invalid entry is dropped.
REQ-021 SHALL retire in order, at most one entry per cycle: at an edge where entry[head] has valid and done set, register commit_en=1, commit_reg=dest and commit_data=data, clear the entry's valid bit, and increment head modulo DEPTH.
REQ-022 SHALL register commit_en=0 at every other edge; commit_reg and commit_data hold their previous values when commit_en is 0.
REQ-023 SHALL give head-entry latency as follows: writeback sampled at edge k, then commit_en is high for exactly the one cycle following edge k+1.
REQ-024 SHALL, when allocate and retire occur at the same edge, leave count unchanged; each alone changes count by +1 or -1.
REQ-025 SHALL compute alloc_ready from the registered count, so a full buffer refuses allocation even at an edge where it retires.
REQ-026 SHALL accept a writeback and an allocation at the same edge; the writeback targets only an already-valid entry.
REQ-027 SHALL wrap both pointers from DEPTH-1 to 0 without a gap.

Reset
REQ-028 SHALL, while reset=1, immediately force head=0, tail=0, count=0, all valid and done bits=0, commit_en=0, commit_reg=0 and commit_data=0.
REQ-029 SHALL discard all in-flight entries on a reset that arrives mid-operation, with no commit issued for them.

Configuration
REQ-030 SHALL, with macro ROB_FLUSH_EN defined, add input port flush (1 bit): at a rising edge with flush=1, clear all valid and done bits, set head=tail=count=0, and register commit_en=0.
REQ-031 SHALL give flush priority over alloc, writeback and retire at the same edge.
REQ-032 SHALL, without ROB_FLUSH_EN, have no flush port and no flush logic.

Verification
REQ-033 SHALL verify basic commit: alloc dest=5, writeback tag 0 with data 0x1234 -> one commit_en pulse with commit_reg=5 and commit_data=0x1234; count returns to 0.
REQ-034 SHALL verify in-order retire: alloc tags 0,1,2; writeback order 2,1,0 with data 0xAAA2, 0xAAA1, 0xAAA0 -> commits in order tag 0,1,2 on consecutive cycles after the tag-0 writeback.
REQ-035 SHALL verify the full boundary: 8 allocs with no writebacks -> alloc_ready=0 and count=8; a 9th alloc_valid is ignored and alloc_tag stays 0.
REQ-036 SHALL verify wrap-around: 20 alloc/writeback/commit cycles -> tags cycle 0 to 7 and back to 0, all 20 commits appear in order, and nothing is lost.
REQ-037 SHALL verify asynchronous reset: assert reset mid-cycle with 3 entries pending -> count=0 and commit_en=0 immediately, and no commit follows.
REQ-038 SHALL verify flush (ROB_FLUSH_EN defined): 4 entries pending, flush together with alloc_valid -> count=0 and alloc_tag=0 next cycle, with no commits.
